// File: rtl/fetch_sequencer.sv
// Program-flow controller: req/done run FSM, PC with absolute/relative branches
// through a run-time writable jump table, ALU flag registers and a retire counter.
module fetch_sequencer #(
  parameter int             D          = 12,
  parameter int             LW         = 5,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter logic [D-1:0]   HALT_ADDR  = D'(128),
  parameter int             CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          absj,
  input  logic          relj,
  input  logic [1:0]    br_cond,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_wr_en,
  input  logic [LW-1:0] lut_wr_idx,
  input  logic [D-1:0]  lut_wr_data,
  input  logic          flag_en,
  input  logic          zero_i,
  input  logic          pari_i,
  input  logic          sc_i,
  input  logic          sc_en,
  input  logic          sc_clr,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          zeroQ,
  output logic          pariQ,
  output logic          scQ,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t       state, state_nxt;
  logic [D-1:0] lut [2**LW];
  logic [D-1:0] lut_q, pc_nxt;
  logic         at_halt, retire, cond, start;

  assign lut_q   = lut[lut_idx];
  assign at_halt = (prog_ctr == HALT_ADDR);
  assign start   = (state == IDLE) && req;
  // Halt check wins over stall and jumps: a halted PC never retires.
  assign retire  = (state == RUN) && !at_halt && !stall;
  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    cond = 1'b1;
    case (br_cond)
      2'b01:   cond = zeroQ;
      2'b10:   cond = pariQ;
      2'b11:   cond = scQ;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)     state_nxt = RUN;
      RUN:     if (at_halt) state_nxt = DONE;
      DONE:    if (!req)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = prog_ctr;
    if (start)
      pc_nxt = START_ADDR;
    else if (retire) begin
      if (absj && cond)      pc_nxt = lut_q;
      else if (relj && cond) pc_nxt = prog_ctr + lut_q;
      else                   pc_nxt = prog_ctr + D'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog_ctr  <= START_ADDR;
      instr_cnt <= '0;
    end else begin
      prog_ctr <= pc_nxt;
      if (start)
        instr_cnt <= '0;
      else if (retire && (instr_cnt != '1))
        instr_cnt <= instr_cnt + CW'(1);
    end
  end

  // Flags are sampled by cond before this edge, so a same-edge write is not seen by the branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zeroQ <= 1'b0;
      pariQ <= 1'b0;
      scQ   <= 1'b0;
    end else if (retire) begin
      if (flag_en) begin
        zeroQ <= zero_i;
        pariQ <= pari_i;
      end
      if (sc_clr)     scQ <= 1'b0;
      else if (sc_en) scQ <= sc_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**LW; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, stall, absj, relj, lut_wr_en, flag_en, zero_i, pari_i, sc_i, sc_en, sc_clr;
  logic [1:0]  br_cond;
  logic [4:0]  lut_idx, lut_wr_idx;
  logic [11:0] lut_wr_data, prog_ctr;
  logic        running, done, zeroQ, pariQ, scQ;
  logic [15:0] instr_cnt;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .absj(absj), .relj(relj),
    .br_cond(br_cond), .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data), .flag_en(flag_en), .zero_i(zero_i), .pari_i(pari_i),
    .sc_i(sc_i), .sc_en(sc_en), .sc_clr(sc_clr), .prog_ctr(prog_ctr), .running(running),
    .done(done), .zeroQ(zeroQ), .pariQ(pariQ), .scQ(scQ), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        req, stall, absj, relj;
    bit [1:0]  br_cond;
    bit [4:0]  lut_idx;
    bit        wen;
    bit [4:0]  widx;
    bit [11:0] wdata;
    bit        flag_en, zero_i, pari_i, sc_i, sc_en, sc_clr;
  } vec_t;

  typedef struct {
    vec_t      v;
    bit [11:0] pc;
    bit [15:0] cnt;
    bit        run, zero;
  } row_t;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: phase 0 = waiting, 1 = executing, 2 = finished
  int        m_phase;
  bit [11:0] m_pc;
  bit [15:0] m_cnt;
  bit        m_zero, m_pari, m_sc;
  bit [11:0] m_lut [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic row_t r(bit rq, bit st, bit aj, bit rj, bit [1:0] bc, bit [4:0] ix,
                             bit we, bit [4:0] wi, bit [11:0] wd, bit fe, bit zi,
                             bit [11:0] epc, bit [15:0] ecnt, bit erun, bit ez);
    row_t t;
    t.v = nop();
    t.v.req = rq; t.v.stall = st; t.v.absj = aj; t.v.relj = rj; t.v.br_cond = bc;
    t.v.lut_idx = ix; t.v.wen = we; t.v.widx = wi; t.v.wdata = wd;
    t.v.flag_en = fe; t.v.zero_i = zi;
    t.pc = epc; t.cnt = ecnt; t.run = erun; t.zero = ez;
    return t;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 12'd0; m_cnt = 16'd0;
    m_zero = 0; m_pari = 0; m_sc = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 12'd0;
  endtask

  task automatic model_edge(input vec_t v);
    bit        c;
    bit [11:0] tgt;
    tgt = m_lut[v.lut_idx];
    c = (v.br_cond == 2'd0) ? 1'b1 : (v.br_cond == 2'd1) ? m_zero :
        (v.br_cond == 2'd2) ? m_pari : m_sc;
    if (m_phase == 0) begin
      if (v.req) begin m_phase = 1; m_pc = 12'd0; m_cnt = 16'd0; end
    end else if (m_phase == 1) begin
      if (m_pc == 12'd128) m_phase = 2;
      else if (!v.stall) begin
        if (v.absj && c)      m_pc = tgt;
        else if (v.relj && c) m_pc = 12'((int'(m_pc) + int'(tgt)) % 4096);
        else                  m_pc = 12'((int'(m_pc) + 1) % 4096);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (v.flag_en) begin m_zero = v.zero_i; m_pari = v.pari_i; end
        if (v.sc_clr) m_sc = 0; else if (v.sc_en) m_sc = v.sc_i;
      end
    end else if (!v.req) m_phase = 0;
    if (v.wen) m_lut[v.widx] = v.wdata;
  endtask

  task automatic compare_model();
    chk("pc", 32'(prog_ctr), 32'(m_pc));
    chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
    chk("running", 32'(running), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("zeroQ", 32'(zeroQ), 32'(m_zero));
    chk("pariQ", 32'(pariQ), 32'(m_pari));
    chk("scQ", 32'(scQ), 32'(m_sc));
  endtask

  // Called just after a negedge: drive, take the rising edge, check 1 time unit later.
  task automatic step(input vec_t v);
    req = v.req; stall = v.stall; absj = v.absj; relj = v.relj; br_cond = v.br_cond;
    lut_idx = v.lut_idx; lut_wr_en = v.wen; lut_wr_idx = v.widx; lut_wr_data = v.wdata;
    flag_en = v.flag_en; zero_i = v.zero_i; pari_i = v.pari_i;
    sc_i = v.sc_i; sc_en = v.sc_en; sc_clr = v.sc_clr;
    @(posedge clk);
    model_edge(v);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", 32'(prog_ctr), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_flags", {29'd0, zeroQ, pariQ, scQ}, 32'd0);
    chk("rst_state", {30'd0, running, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  row_t tbl [19];
  vec_t v;

  initial begin
    reset = 1'b1;
    req = 0; stall = 0; absj = 0; relj = 0; br_cond = 0; lut_idx = 0; lut_wr_en = 0;
    lut_wr_idx = 0; lut_wr_data = 0; flag_en = 0; zero_i = 0; pari_i = 0;
    sc_i = 0; sc_en = 0; sc_clr = 0;

    //            rq st aj rj bc ix we wi wd      fe zi   pc      cnt run zero
    tbl[0]  = r(1, 0, 0, 0, 0, 0, 1, 3, 12'd40,  0, 0, 12'd0,   0, 1, 0);
    tbl[1]  = r(0, 0, 0, 0, 0, 0, 1, 2, 12'hFFE, 0, 0, 12'd1,   1, 1, 0);
    tbl[2]  = r(0, 0, 0, 0, 0, 0, 1, 4, 12'd10,  0, 0, 12'd2,   2, 1, 0);
    tbl[3]  = r(0, 0, 0, 0, 0, 0, 1, 6, 12'd7,   0, 0, 12'd3,   3, 1, 0);
    tbl[4]  = r(0, 0, 0, 0, 0, 0, 0, 0, 12'd0,   0, 0, 12'd4,   4, 1, 0);
    tbl[5]  = r(0, 0, 0, 0, 0, 0, 0, 0, 12'd0,   0, 0, 12'd5,   5, 1, 0);
    tbl[6]  = r(0, 0, 1, 0, 0, 3, 0, 0, 12'd0,   0, 0, 12'd40,  6, 1, 0);
    tbl[7]  = r(0, 0, 1, 0, 0, 4, 0, 0, 12'd0,   0, 0, 12'd10,  7, 1, 0);
    tbl[8]  = r(0, 0, 0, 1, 1, 2, 0, 0, 12'd0,   1, 1, 12'd11,  8, 1, 1);
    tbl[9]  = r(0, 0, 1, 0, 0, 4, 0, 0, 12'd0,   0, 0, 12'd10,  9, 1, 1);
    tbl[10] = r(0, 0, 0, 1, 1, 2, 0, 0, 12'd0,   0, 0, 12'd8,  10, 1, 1);
    tbl[11] = r(0, 0, 1, 0, 0, 5, 0, 0, 12'd0,   0, 0, 12'd0,  11, 1, 1);
    tbl[12] = r(0, 0, 0, 1, 0, 2, 0, 0, 12'd0,   0, 0, 12'hFFE,12, 1, 1);
    tbl[13] = r(0, 0, 1, 0, 0, 6, 0, 0, 12'd0,   0, 0, 12'd7,  13, 1, 1);
    tbl[14] = r(0, 1, 1, 0, 0, 3, 1, 7, 12'd99,  1, 0, 12'd7,  13, 1, 1);
    tbl[15] = r(0, 1, 1, 0, 0, 3, 0, 0, 12'd0,   1, 0, 12'd7,  13, 1, 1);
    tbl[16] = r(0, 1, 1, 0, 0, 3, 0, 0, 12'd0,   1, 0, 12'd7,  13, 1, 1);
    tbl[17] = r(0, 0, 1, 0, 0, 3, 0, 0, 12'd0,   0, 0, 12'd40, 14, 1, 1);
    tbl[18] = r(0, 0, 1, 0, 0, 7, 0, 0, 12'd0,   0, 0, 12'd99, 15, 1, 1);

    @(negedge clk);
    do_reset();

    // Directed branch / stall table
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v);
      chk($sformatf("tbl%0d_pc", i), 32'(prog_ctr), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_cnt", i), 32'(instr_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_run", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_zero", i), 32'(zeroQ), 32'(tbl[i].zero));
    end

    // Straight-line run to HALT_ADDR, then handshake
    do_reset();
    v = nop(); v.req = 1;
    step(v);
    chk("t1_running", 32'(running), 32'd1);
    v.req = 0;
    for (int i = 0; i < 128; i++) step(v);
    chk("t1_pc_halt", 32'(prog_ctr), 32'd128);
    chk("t1_cnt128", 32'(instr_cnt), 32'd128);
    chk("t1_not_done", 32'(done), 32'd0);
    v.req = 1; v.absj = 1; v.stall = 1;
    step(v);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cnt_hold", 32'(instr_cnt), 32'd128);
    chk("t1_pc_hold", 32'(prog_ctr), 32'd128);
    v = nop(); v.req = 1;
    step(v); step(v);
    chk("t5_stay_done", 32'(done), 32'd1);
    v.req = 0;
    step(v);
    chk("t5_idle", {30'd0, running, done}, 32'd0);
    v.req = 1;
    step(v);
    chk("t5_restart_pc", 32'(prog_ctr), 32'd0);
    chk("t5_restart_cnt", 32'(instr_cnt), 32'd0);
    chk("t5_restart_run", 32'(running), 32'd1);

    // sc_clr priority, then abort mid-run at PC 50
    v = nop(); v.wen = 1; v.widx = 1; v.wdata = 12'd77; v.sc_en = 1; v.sc_i = 1;
    step(v);
    chk("t6_sc_set", 32'(scQ), 32'd1);
    v = nop(); v.sc_clr = 1; v.sc_en = 1; v.sc_i = 1;
    step(v);
    chk("t6_sc_clr", 32'(scQ), 32'd0);
    v = nop(); v.sc_en = 1; v.sc_i = 1; v.flag_en = 1; v.zero_i = 1; v.pari_i = 1;
    step(v);
    v = nop();
    for (int i = 0; i < 100 && prog_ctr != 12'd50; i++) step(v);
    chk("t6_at50", 32'(prog_ctr), 32'd50);
    do_reset();
    v = nop(); v.req = 1;
    step(v);
    v = nop(); v.absj = 1; v.lut_idx = 1;
    step(v);
    chk("t6_lut_lost", 32'(prog_ctr), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      v = nop();
      v.req     = ($urandom_range(0, 3) != 0);
      v.stall   = ($urandom_range(0, 4) == 0);
      v.absj    = ($urandom_range(0, 7) == 0);
      v.relj    = ($urandom_range(0, 7) == 0);
      v.br_cond = 2'($urandom);
      v.lut_idx = 5'($urandom);
      v.wen     = ($urandom_range(0, 3) == 0);
      v.widx    = 5'($urandom);
      v.wdata   = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 140)) : 12'($urandom);
      v.flag_en = 1'($urandom); v.zero_i = 1'($urandom); v.pari_i = 1'($urandom);
      v.sc_i    = 1'($urandom); v.sc_en  = 1'($urandom); v.sc_clr = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
